// File: rtl/mem_resp_unit.sv
// mem_resp_unit: data-memory responder for the processor load/store interface.
// It accepts one byte, half or word request at a time through a valid/ready
// handshake and returns exactly one response LATENCY cycles after the accept.
// Misaligned, out-of-range and illegal-size accesses come back with resp_err
// set and never touch storage.
//
// Ports:
//   clk, reset          clock (rising edge), synchronous active-high reset
//   req_valid/req_ready request handshake; a transfer happens when both are high at a rising edge
//   req_write           1 = store, 0 = load
//   req_size            00 byte, 01 half, 10 word, 11 illegal
//   req_addr            byte address
//   req_wdata           right-aligned store data
//   resp_valid          one-cycle response pulse
//   resp_rdata          zero-extended, right-aligned load data (0 for stores and errors)
//   resp_err            response error flag
module mem_resp_unit #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic [31:0] storage_q [DEPTH_WORDS];

  logic        accept;
  logic        commit;
  logic        cur_write;
  logic [1:0]  cur_size;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic        cur_err;
  logic [AW-1:0] cur_idx;
  logic [31:0] rd_word;
  logic [31:0] load_data;
  logic [31:0] store_word;
  logic        mem_we;

  // Held in reset: no transfer may be taken.
  assign req_ready = (state_q == S_IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          write_d = req_write;
          size_d  = req_size;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (LATENCY <= 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The commit happens on the edge entering RESP. With LATENCY==1 that is the
  // accept edge itself, so the live request fields are used instead of the
  // latched copies.
  always_comb begin
    if (state_q == S_IDLE) begin
      cur_write = req_write;
      cur_size  = req_size;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
    end else begin
      cur_write = write_q;
      cur_size  = size_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
    end
  end

  assign commit  = (state_d == S_RESP) && (state_q != S_RESP) && !reset;
  assign cur_idx = cur_addr[2 +: AW];

  always_comb begin
    cur_err = 1'b0;
    if (cur_size == 2'b11) cur_err = 1'b1;
    if ((cur_size == 2'b01) && cur_addr[0]) cur_err = 1'b1;
    if ((cur_size == 2'b10) && (cur_addr[1:0] != 2'b00)) cur_err = 1'b1;
    if ({1'b0, cur_addr} >= ADDR_LIMIT) cur_err = 1'b1;
  end

  assign rd_word = storage_q[cur_idx];

  always_comb begin
    load_data  = '0;
    store_word = rd_word;
    case (cur_size)
      2'b00: begin
        load_data[7:0] = rd_word[8*cur_addr[1:0] +: 8];
        store_word[8*cur_addr[1:0] +: 8] = cur_wdata[7:0];
      end
      2'b01: begin
        load_data[15:0] = rd_word[16*cur_addr[1] +: 16];
        store_word[16*cur_addr[1] +: 16] = cur_wdata[15:0];
      end
      default: begin
        load_data  = rd_word;
        store_word = cur_wdata;
      end
    endcase
  end

  assign mem_we = commit && cur_write && !cur_err;

  always_comb begin
    resp_valid_d = commit;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    if (commit) begin
      resp_err_d   = cur_err;
      resp_rdata_d = (cur_err || cur_write) ? '0 : load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      size_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) storage_q[cur_idx] <= store_word;
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule
